counter_sweep_ctrl: RTL

//   Sequencer for the n-bit up/down/load counter. Drives its load_en, counter_in
//   and up_down inputs and watches its counter_out to run triangle sweeps:
//   lo -> hi -> lo, repeated a programmed number of times.

---
 rtl/counter_sweep_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
//   Sequencer for an external n-bit up/down/load counter. It runs triangle
//   sweeps lo -> hi -> lo a programmed number of times by driving the counter's
//   load_en / counter_in / up_down inputs and watching its counter_out.
//   The counter has no enable, so "hold" means loading its own current value.
//
//   Optional feature macro: SWEEP_CTRL_DWELL_EN
//     When defined, each turnaround (the hi turnaround and every non-final lo
//     turnaround) is held so the turnaround value is seen for DWELL_CYCLES+1
//     cycles. The last DWELL cycle already issues the new direction.
//     When undefined there is no DWELL state and DWELL_CYCLES is unused.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   start         in   run request, sampled only in IDLE
//   abort         in   stop the current run (LOAD/UP/DOWN/DWELL only)
//   lo_bound      in   sweep low endpoint, latched at start
//   hi_bound      in   sweep high endpoint, latched at start
//   num_sweeps    in   number of full lo->hi->lo sweeps, latched at start
//   cnt_value     in   counter_out feedback
//   cnt_load_en   out  counter load_en
//   cnt_load_val  out  counter counter_in
//   cnt_up_down   out  counter up_down (1 = up)
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse (the DONE state)
//   err           out  one-cycle pulse after a rejected start
//   sweeps_done   out  completed sweeps of the current/last run
//   dbg_state_o   out  current FSM state encoding
//
// Handshake: start is a level sampled on each rising edge while IDLE; a valid
// request is accepted on that edge (busy rises next cycle), an invalid one
// yields err in the following cycle. start is ignored whenever busy is high.
module counter_sweep_ctrl #(
   parameter int CNT_WIDTH    = 3,
   parameter int SWEEP_WIDTH  = 4,
   parameter int DWELL_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [CNT_WIDTH-1:0]   lo_bound,
   input  logic [CNT_WIDTH-1:0]   hi_bound,
   input  logic [SWEEP_WIDTH-1:0] num_sweeps,
   input  logic [CNT_WIDTH-1:0]   cnt_value,
   output logic                   cnt_load_en,
   output logic [CNT_WIDTH-1:0]   cnt_load_val,
   output logic                   cnt_up_down,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [SWEEP_WIDTH-1:0] sweeps_done,
   output logic [2:0]             dbg_state_o
);

   if (DWELL_CYCLES < 1) begin : g_bad_dwell
      $error("DWELL_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_UP    = 3'd2,
      S_DOWN  = 3'd3,
`ifdef SWEEP_CTRL_DWELL_EN
      S_DWELL = 3'd5,
`endif
      S_DONE  = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   lo_q, lo_d;
   logic [CNT_WIDTH-1:0]   hi_q, hi_d;
   logic [SWEEP_WIDTH-1:0] num_q, num_d;
   logic [SWEEP_WIDTH-1:0] sweeps_q, sweeps_d;
   logic                   err_q, err_d;

`ifdef SWEEP_CTRL_DWELL_EN
   localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   logic [DWELL_W-1:0]     dwell_q, dwell_d;
   logic                   dir_q, dir_d;   // direction to take when DWELL ends
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         lo_q     <= '0;
         hi_q     <= '0;
         num_q    <= '0;
         sweeps_q <= '0;
         err_q    <= 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
         dwell_q  <= '0;
         dir_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         num_q    <= num_d;
         sweeps_q <= sweeps_d;
         err_q    <= err_d;
`ifdef SWEEP_CTRL_DWELL_EN
         dwell_q  <= dwell_d;
         dir_q    <= dir_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      lo_d         = lo_q;
      hi_d         = hi_q;
      num_d        = num_q;
      sweeps_d     = sweeps_q;
      err_d        = 1'b0;
      cnt_load_en  = 1'b1;        // default decode is hold
      cnt_load_val = cnt_value;
      cnt_up_down  = 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
      dwell_d      = dwell_q;
      dir_d        = dir_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((lo_bound < hi_bound) && (num_sweeps != '0)) begin
                  lo_d     = lo_bound;
                  hi_d     = hi_bound;
                  num_d    = num_sweeps;
                  sweeps_d = '0;
                  state_d  = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            cnt_load_val = lo_q;
            state_d      = S_UP;
         end
         S_UP: begin
            cnt_load_en = 1'b0;
            cnt_up_down = 1'b1;
            if (cnt_value >= hi_q) begin
`ifdef SWEEP_CTRL_DWELL_EN
               cnt_load_en = 1'b1;
               cnt_up_down = 1'b0;
               dwell_d     = '0;
               dir_d       = 1'b0;
               state_d     = S_DWELL;
`else
               cnt_up_down = 1'b0;   // counter turns to hi-1 at this edge
               state_d     = S_DOWN;
`endif
            end
         end
         S_DOWN: begin
            cnt_load_en = 1'b0;
            cnt_up_down = 1'b0;
            if (cnt_value <= lo_q) begin
               sweeps_d = sweeps_q + SWEEP_WIDTH'(1);
               if ((sweeps_q + SWEEP_WIDTH'(1)) == num_q) begin
                  cnt_load_en = 1'b1;    // final lo: hold and finish
                  state_d     = S_DONE;
               end else begin
`ifdef SWEEP_CTRL_DWELL_EN
                  cnt_load_en = 1'b1;
                  dwell_d     = '0;
                  dir_d       = 1'b1;
                  state_d     = S_DWELL;
`else
                  cnt_up_down = 1'b1;
                  state_d     = S_UP;
`endif
               end
            end
         end
`ifdef SWEEP_CTRL_DWELL_EN
         S_DWELL: begin
            // Last dwell cycle already moves, so the turnaround value is
            // visible for DWELL_CYCLES+1 cycles including the entry cycle.
            if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
               cnt_load_en = 1'b0;
               cnt_up_down = dir_q;
               state_d     = dir_q ? S_UP : S_DOWN;
            end else begin
               dwell_d = dwell_q + DWELL_W'(1);
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort lets this cycle's counter decode stand but freezes the status.
      if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
         state_d  = S_IDLE;
         sweeps_d = sweeps_q;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign err         = err_q;
   assign sweeps_done = sweeps_q;
   assign dbg_state_o = state_q;

endmodule
